// File: rtl/control_unit.sv
// Main instruction decoder: maps opcode/function to every datapath control,
// registered with one-cycle latency and cleared asynchronously to a NOP.
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] function_val,
    output logic [1:0] reg_dst,
    output logic       reg_write,
    output logic [1:0] immediacy,
    output logic [2:0] logic_fn,
    output logic [1:0] functionals,
    output logic       data_read,
    output logic       data_write,
    output logic [1:0] reg_input_data,
    output logic [3:0] branch_type,
    output logic [1:0] counter_selector,
    output logic       illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b000001;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BLTZ  = 6'b000110;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_COMP  = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_XOR   = 6'b100101;
    localparam logic [5:0] FN_SHLLV = 6'b101010;
    localparam logic [5:0] FN_SHRL  = 6'b011111;
    localparam logic [5:0] FN_SHRA  = 6'b011110;

    logic [1:0] reg_dst_d,          reg_dst_q;
    logic       reg_write_d,        reg_write_q;
    logic [1:0] immediacy_d,        immediacy_q;
    logic [2:0] logic_fn_d,         logic_fn_q;
    logic [1:0] functionals_d,      functionals_q;
    logic       data_read_d,        data_read_q;
    logic       data_write_d,       data_write_q;
    logic [1:0] reg_input_data_d,   reg_input_data_q;
    logic [3:0] branch_type_d,      branch_type_q;
    logic [1:0] counter_selector_d, counter_selector_q;
    logic       illegal_d,          illegal_q;

    // Combinational decode; unlisted fields stay at the all-zero NOP value.
    always_comb begin
        reg_dst_d          = 2'b00;
        reg_write_d        = 1'b0;
        immediacy_d        = 2'b00;
        logic_fn_d         = 3'b000;
        functionals_d      = 2'b00;
        data_read_d        = 1'b0;
        data_write_d       = 1'b0;
        reg_input_data_d   = 2'b00;
        branch_type_d      = 4'b0000;
        counter_selector_d = 2'b00;
        illegal_d          = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reg_dst_d   = 2'b01;
                reg_write_d = 1'b1;
                case (function_val)
                    FN_ADD:   logic_fn_d = 3'b000;
                    FN_COMP:  logic_fn_d = 3'b001;
                    FN_AND:   logic_fn_d = 3'b010;
                    FN_XOR:   logic_fn_d = 3'b011;
                    FN_SHLLV: begin
                        logic_fn_d    = 3'b100;
                        functionals_d = 2'b01;
                    end
                    FN_SHRL: begin
                        immediacy_d   = 2'b10;
                        logic_fn_d    = 3'b101;
                        functionals_d = 2'b01;
                    end
                    FN_SHRA: begin
                        immediacy_d   = 2'b10;
                        logic_fn_d    = 3'b110;
                        functionals_d = 2'b01;
                    end
                    default: begin
                        // Undefined function collapses back to a full NOP.
                        reg_dst_d   = 2'b00;
                        reg_write_d = 1'b0;
                        illegal_d   = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                reg_write_d      = 1'b1;
                immediacy_d      = 2'b01;
                data_read_d      = 1'b1;
                reg_input_data_d = 2'b01;
            end
            OP_SW: begin
                immediacy_d  = 2'b01;
                data_write_d = 1'b1;
            end
            OP_ADDI: begin
                reg_write_d = 1'b1;
                immediacy_d = 2'b01;
            end
            OP_BEQ, OP_BLTZ: begin
                logic_fn_d         = 3'b001;
                functionals_d      = 2'b10;
                branch_type_d      = (opcode == OP_BEQ) ? 4'b0001 : 4'b0010;
                counter_selector_d = 2'b01;
            end
            OP_J: begin
                counter_selector_d = 2'b10;
            end
            OP_JAL: begin
                reg_dst_d          = 2'b10;
                reg_write_d        = 1'b1;
                reg_input_data_d   = 2'b10;
                counter_selector_d = 2'b10;
            end
            default: begin
                illegal_d = 1'b1;
            end
        endcase
    end

    // Output registers; reset forces a NOP without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_dst_q          <= 2'b00;
            reg_write_q        <= 1'b0;
            immediacy_q        <= 2'b00;
            logic_fn_q         <= 3'b000;
            functionals_q      <= 2'b00;
            data_read_q        <= 1'b0;
            data_write_q       <= 1'b0;
            reg_input_data_q   <= 2'b00;
            branch_type_q      <= 4'b0000;
            counter_selector_q <= 2'b00;
            illegal_q          <= 1'b0;
        end else begin
            reg_dst_q          <= reg_dst_d;
            reg_write_q        <= reg_write_d;
            immediacy_q        <= immediacy_d;
            logic_fn_q         <= logic_fn_d;
            functionals_q      <= functionals_d;
            data_read_q        <= data_read_d;
            data_write_q       <= data_write_d;
            reg_input_data_q   <= reg_input_data_d;
            branch_type_q      <= branch_type_d;
            counter_selector_q <= counter_selector_d;
            illegal_q          <= illegal_d;
        end
    end

    assign reg_dst          = reg_dst_q;
    assign reg_write        = reg_write_q;
    assign immediacy        = immediacy_q;
    assign logic_fn         = logic_fn_q;
    assign functionals      = functionals_q;
    assign data_read        = data_read_q;
    assign data_write       = data_write_q;
    assign reg_input_data   = reg_input_data_q;
    assign branch_type      = branch_type_q;
    assign counter_selector = counter_selector_q;
    assign illegal          = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: expected control words are queued when an
// instruction is driven and compared one cycle later.
module tb_control_unit;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] function_val;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic [1:0] immediacy;
    logic [2:0] logic_fn;
    logic [1:0] functionals;
    logic       data_read;
    logic       data_write;
    logic [1:0] reg_input_data;
    logic [3:0] branch_type;
    logic [1:0] counter_selector;
    logic       illegal;

    int n_checks = 0;
    int n_fail   = 0;
    logic [20:0] exp_q[$];
    logic [20:0] obs;

    control_unit dut (
        .clk(clk), .reset(reset), .opcode(opcode), .function_val(function_val),
        .reg_dst(reg_dst), .reg_write(reg_write), .immediacy(immediacy),
        .logic_fn(logic_fn), .functionals(functionals), .data_read(data_read),
        .data_write(data_write), .reg_input_data(reg_input_data),
        .branch_type(branch_type), .counter_selector(counter_selector),
        .illegal(illegal)
    );

    assign obs = {reg_dst, reg_write, immediacy, logic_fn, functionals, data_read,
                  data_write, reg_input_data, branch_type, counter_selector, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Reference decode written from the instruction table.
    function automatic logic [20:0] model(input logic [5:0] op, input logic [5:0] fn);
        logic [1:0] rd = 2'd0; logic rw = 1'b0; logic [1:0] imm = 2'd0;
        logic [2:0] lf = 3'd0; logic [1:0] fu = 2'd0; logic dr = 1'b0;
        logic dw = 1'b0; logic [1:0] rid = 2'd0; logic [3:0] bt = 4'd0;
        logic [1:0] cs = 2'd0; logic il = 1'b0;
        if (op == 6'b000000) begin
            if      (fn == 6'b100000) begin rd = 2'b01; rw = 1'b1; lf = 3'b000; end
            else if (fn == 6'b100010) begin rd = 2'b01; rw = 1'b1; lf = 3'b001; end
            else if (fn == 6'b100100) begin rd = 2'b01; rw = 1'b1; lf = 3'b010; end
            else if (fn == 6'b100101) begin rd = 2'b01; rw = 1'b1; lf = 3'b011; end
            else if (fn == 6'b101010) begin rd = 2'b01; rw = 1'b1; lf = 3'b100; fu = 2'b01; end
            else if (fn == 6'b011111) begin rd = 2'b01; rw = 1'b1; imm = 2'b10; lf = 3'b101; fu = 2'b01; end
            else if (fn == 6'b011110) begin rd = 2'b01; rw = 1'b1; imm = 2'b10; lf = 3'b110; fu = 2'b01; end
            else il = 1'b1;
        end
        else if (op == 6'b100011) begin rw = 1'b1; imm = 2'b01; dr = 1'b1; rid = 2'b01; end
        else if (op == 6'b101011) begin imm = 2'b01; dw = 1'b1; end
        else if (op == 6'b000001) begin rw = 1'b1; imm = 2'b01; end
        else if (op == 6'b000100) begin lf = 3'b001; fu = 2'b10; bt = 4'b0001; cs = 2'b01; end
        else if (op == 6'b000110) begin lf = 3'b001; fu = 2'b10; bt = 4'b0010; cs = 2'b01; end
        else if (op == 6'b000010) begin cs = 2'b10; end
        else if (op == 6'b000011) begin rd = 2'b10; rw = 1'b1; rid = 2'b10; cs = 2'b10; end
        else il = 1'b1;
        return {rd, rw, imm, lf, fu, dr, dw, rid, bt, cs, il};
    endfunction

    // Drive an instruction on the falling edge, queue its decode, sample after the rise.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input string name);
        logic [20:0] e;
        @(negedge clk);
        opcode = op;
        function_val = fn;
        exp_q.push_back(model(op, fn));
        @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got %h required a queued expectation", name, obs);
        end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
                n_fail++;
                $display("FAIL %s: got %h required %h (op %b fn %b)", name, obs, e, op, fn);
            end
        end
        n_checks++;
        if ((data_read & data_write) !== 1'b0 || (reg_write & data_write) !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_invariant: got rd=%b wr=%b rw=%b required exclusive", name,
                     data_read, data_write, reg_write);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        opcode = 6'b100011;
        function_val = 6'b000000;
        #1;
        n_checks++;
        if (obs !== 21'd0) begin n_fail++; $display("FAIL reset_init: got %h required %h", obs, 21'd0); end
        @(negedge clk);
        reset = 1'b0;
        issue(6'b100011, 6'b000000, "reset_lw");
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (obs !== 21'd0) begin n_fail++; $display("FAIL reset_async: got %h required %h", obs, 21'd0); end
        @(posedge clk);
        #1;
        n_checks++;
        if (obs !== 21'd0) begin n_fail++; $display("FAIL reset_hold: got %h required %h", obs, 21'd0); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (obs !== model(6'b100011, 6'b000000)) begin
            n_fail++;
            $display("FAIL reset_release: got %h required %h", obs, model(6'b100011, 6'b000000));
        end
    endtask

    task automatic test_rtype_sweep();
        logic [5:0] fns [7] = '{6'b100010, 6'b101010, 6'b100000, 6'b011111, 6'b011110, 6'b100100, 6'b100101};
        logic [2:0] lfs [7] = '{3'b001, 3'b100, 3'b000, 3'b101, 3'b110, 3'b010, 3'b011};
        for (int i = 0; i < 7; i++) begin
            issue(6'b000000, fns[i], "rtype");
            n_checks++;
            if (logic_fn !== lfs[i] || reg_dst !== 2'b01 || reg_write !== 1'b1) begin
                n_fail++;
                $display("FAIL rtype_fields: got fn=%b rd=%b rw=%b required fn=%b rd=01 rw=1",
                         logic_fn, reg_dst, reg_write, lfs[i]);
            end
        end
    endtask

    task automatic test_memory();
        issue(6'b100011, 6'b101010, "lw");
        n_checks++;
        if ({data_read, reg_input_data, immediacy, reg_write} !== 6'b1_01_01_1) begin
            n_fail++;
            $display("FAIL lw_fields: got %b required 101011", {data_read, reg_input_data, immediacy, reg_write});
        end
        issue(6'b101011, 6'b100000, "sw");
        n_checks++;
        if ({data_write, reg_write} !== 2'b10) begin
            n_fail++;
            $display("FAIL sw_fields: got %b required 10", {data_write, reg_write});
        end
    endtask

    task automatic test_imm_branch();
        issue(6'b000001, 6'b000000, "addi");
        issue(6'b000100, 6'b000000, "beq");
        n_checks++;
        if ({branch_type, counter_selector, functionals, logic_fn, reg_write} !== 12'b0001_01_10_001_0) begin
            n_fail++;
            $display("FAIL beq_fields: got %b required 000101100010",
                     {branch_type, counter_selector, functionals, logic_fn, reg_write});
        end
        issue(6'b000110, 6'b111111, "bltz");
        issue(6'b000010, 6'b000000, "j");
        issue(6'b000011, 6'b000000, "jal");
    endtask

    task automatic test_illegal();
        issue(6'b111111, 6'b100000, "illegal_op");
        n_checks++;
        if (obs !== 21'd1) begin n_fail++; $display("FAIL illegal_op_word: got %h required %h", obs, 21'd1); end
        issue(6'b000000, 6'b000111, "illegal_fn");
        issue(6'b000000, 6'b100000, "illegal_clear");
        n_checks++;
        if (illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_clear_bit: got %b required 0", illegal); end
    endtask

    task automatic test_latency();
        logic [20:0] held;
        issue(6'b101011, 6'b000000, "lat_sw");
        held = model(6'b101011, 6'b000000);
        #1;
        opcode = 6'b000010;
        #2;
        n_checks++;
        if (obs !== held) begin n_fail++; $display("FAIL latency_hold: got %h required %h", obs, held); end
        @(negedge clk);
        n_checks++;
        if (obs !== held) begin n_fail++; $display("FAIL latency_hold2: got %h required %h", obs, held); end
        exp_q.push_back(model(6'b000010, 6'b000000));
        @(posedge clk);
        #1;
        n_checks++;
        if (obs !== exp_q.pop_front()) begin
            n_fail++;
            $display("FAIL latency_update: got %h required %h", obs, model(6'b000010, 6'b000000));
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [9] = '{6'b000000, 6'b100011, 6'b101011, 6'b000001, 6'b000100,
                                6'b000110, 6'b000010, 6'b000011, 6'b000000};
        logic [5:0] op;
        logic [5:0] fn;
        for (int i = 0; i < 60; i++) begin
            if (i % 4 == 3) op = 6'($urandom_range(0, 63));
            else            op = ops[$urandom_range(0, 8)];
            fn = 6'($urandom_range(0, 63));
            if (i % 3 == 0) fn = 6'b100000 | 6'($urandom_range(0, 7));
            issue(op, fn, "b2b");
        end
    endtask

    initial begin
        test_reset();
        test_rtype_sweep();
        test_memory();
        test_imm_branch();
        test_illegal();
        test_latency();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
